dmem_lsu: RTL and testbench

- Load/store initiator for the word-organised data memory: the requester end of the dmem interface.
- Accepts byte, halfword and word load/store requests from the pipeline MEM stage over a valid/ready handshake.
- Drives the single-port word memory (address, write-enable, write data, combinational read data).
- Performs read-modify-write for sub-word stores, and sign/zero-extends sub-word loads.
- Sits between the MEM pipeline stage and dmem.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/dmem_lsu_if.sv | 30 +++
 rtl/lsu_lane.sv | 44 ++++
 rtl/dmem_lsu.sv | 104 ++++++++++
 tb/tb_dmem_lsu.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the dmem load/store path: access sizes, LSU states and
// the alignment rule used to reject requests before they reach memory.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake from the MEM stage plus the single-port dmem bus.
interface dmem_lsu_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_lane.sv
// Little-endian byte-lane logic: extract+extend for loads, merge for
// sub-word stores. Purely combinational.
module lsu_lane
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_e             size,
  input  logic              is_unsigned,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{off, 3'b000} +: 8];
    half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{(DATA_W-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
        merged    = rdata;
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{(DATA_W-16){half_sel[15] & ~is_unsigned}}, half_sel};
        merged    = rdata;
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: begin
        load_data = rdata;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the word-organised dmem: one outstanding request,
// read-modify-write for sub-word stores, extended sub-word loads.
module dmem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);

  state_e            state, state_nx;
  logic              we_q, uns_q, err_q;
  size_e             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, merge_q, rdata_q;
  logic [DATA_W-1:0] lane_load, lane_merged;
  logic              accept, bad_req, word_store;

  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (bus.mem_rdata),
    .load_data   (lane_load),
    .merged      (lane_merged)
  );

  always_comb begin
    accept     = (state == IDLE) && bus.req_valid;
    bad_req    = misaligned(size_e'(bus.req_size), bus.req_addr[1:0]);
    word_store = we_q && (size_q == SZ_WORD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = bad_req ? RESP : ACCESS;
      ACCESS:  state_nx = (we_q && !word_store) ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write strobe comes from state alone so an async reset kills it at once.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    bus.mem_we     = ((state == ACCESS) && word_store) || (state == WRITE);
    bus.mem_wdata  = '0;
    if (state == WRITE)                     bus.mem_wdata = merge_q;
    else if ((state == ACCESS) && word_store) bus.mem_wdata = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_q    <= bus.req_we;
          uns_q   <= bus.req_unsigned;
          size_q  <= size_e'(bus.req_size);
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          if (bad_req) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ACCESS: begin
          err_q <= 1'b0;
          if (!we_q) begin
            rdata_q <= lane_load;
          end else begin
            rdata_q <= '0;
            merge_q <= lane_merged;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a word-level reference model and a
// per-cycle compare process.
module tb_dmem_lsu;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    int          writes;
    logic [5:0]  waddr;
    logic [31:0] wword;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_W(6), .DATA_W(32)) bus ();
  dmem_lsu #(.ADDR_W(6), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] tbmem   [16];
  logic [31:0] ref_mem [16];
  exp_t        q [$];
  exp_t        f;
  int          n_cmp = 0, n_bad = 0;
  int          neg_count = 0, cur_writes = 0, n_resp = 0;

  assign bus.mem_rdata = tbmem[bus.mem_addr[5:2]];
  always @(posedge clk) if (bus.mem_we) tbmem[bus.mem_addr[5:2]] <= bus.mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain word arithmetic with masks; latency is relative to acceptance.
  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [5:0] addr, input logic [31:0] wd);
    exp_t e;
    int wi = int'(addr) / 4;
    int off = int'(addr) % 4;
    int sh = 8 * off;
    logic [31:0] v, mask;
    e.rdata = 0; e.err = 0; e.writes = 0; e.waddr = 6'(wi * 4); e.wword = 0;
    if (size == 3 || (size == 1 && off % 2 != 0) || (size == 2 && off != 0)) begin
      e.err = 1; e.due = 1;
    end else if (!we) begin
      e.due = 2;
      v = ref_mem[wi] >> sh;
      if (size == 0) begin
        v = v & 32'hFF;
        if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (size == 1) begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      e.rdata = v;
    end else begin
      e.due = (size == 2) ? 2 : 3;
      mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFFFFFF;
      mask = mask << sh;
      e.wword = (ref_mem[wi] & ~mask) | ((wd << sh) & mask);
      ref_mem[wi] = e.wword;
      e.writes = 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    neg_count++;
    if (!rst_n) begin
      cur_writes = 0;
      check("rst_resp_valid", 32'(bus.resp_valid), 0);
      check("rst_mem_we", 32'(bus.mem_we), 0);
    end else begin
      check("req_ready", 32'(bus.req_ready), 32'(q.size() == 0));
      if (bus.mem_we) begin
        if (q.size() == 0) check("stray_we", 32'(bus.mem_we), 0);
        else begin
          f = q[0];
          cur_writes++;
          check("we_cycle", 32'(neg_count), 32'(f.due - 1));
          check("mem_addr", 32'(bus.mem_addr), 32'(f.waddr));
          check("mem_wdata", bus.mem_wdata, f.wword);
        end
      end
      if (q.size() != 0 && q[0].due == neg_count) begin
        f = q.pop_front();
        n_resp++;
        check("resp_valid", 32'(bus.resp_valid), 1);
        check("resp_rdata", bus.resp_rdata, f.rdata);
        check("resp_err", 32'(bus.resp_err), 32'(f.err));
        check("write_count", 32'(cur_writes), 32'(f.writes));
        cur_writes = 0;
      end else begin
        check("resp_idle", 32'(bus.resp_valid), 0);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [5:0] addr, input logic [31:0] wd,
                        input bit hold, input bit pin, input logic [31:0] lit);
    int t = 0;
    exp_t e;
    @(negedge clk); #1;
    while (!bus.req_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!bus.req_ready) begin
      check("ready_timeout", 32'(bus.req_ready), 1);
      return;
    end
    bus.req_valid = 1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    e = model(we, size, uns, addr, wd);
    e.due = e.due + neg_count;
    q.push_back(e);
    if (pin) check("model_pin", e.rdata, lit);
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < 50) begin @(negedge clk); #1; t++; end
    check("idle_timeout", 32'(q.size()), 0);
  endtask

  task automatic mem_check();
    for (int i = 0; i < 16; i++) check("mem_word", tbmem[i], ref_mem[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    int resp_base;
    for (int i = 0; i < 16; i++) begin tbmem[i] = 0; ref_mem[i] = 0; end
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
    bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;

    #3;
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_err", 32'(bus.resp_err), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", bus.mem_wdata, 0);
    @(negedge clk); #1; rst_n = 1;

    // word store / load
    do_req(1, 2, 0, 6'h08, 32'hDEADBEEF, 0, 0, 0); wait_idle();
    check("mem08_word", tbmem[2], 32'hDEADBEEF);
    do_req(0, 2, 0, 6'h08, 0, 0, 1, 32'hDEADBEEF); wait_idle();

    // byte RMW and byte loads
    do_req(1, 0, 0, 6'h0A, 32'h000000A5, 0, 0, 0); wait_idle();
    check("mem08_byte", tbmem[2], 32'hDEA5BEEF);
    do_req(0, 0, 0, 6'h0A, 0, 0, 1, 32'hFFFFFFA5); wait_idle();
    do_req(0, 0, 1, 6'h0A, 0, 0, 1, 32'h000000A5); wait_idle();

    // halfword RMW and loads
    do_req(1, 1, 0, 6'h0E, 32'h00001234, 0, 0, 0); wait_idle();
    check("mem0c_half", tbmem[3], 32'h12340000);
    do_req(0, 1, 0, 6'h0E, 0, 0, 1, 32'h00001234); wait_idle();
    do_req(1, 1, 0, 6'h0C, 32'h00008000, 0, 0, 0); wait_idle();
    do_req(0, 1, 0, 6'h0C, 0, 0, 1, 32'hFFFF8000); wait_idle();

    // errors: no writes, zero data
    do_req(0, 2, 0, 6'h05, 0, 0, 1, 0); wait_idle();
    do_req(1, 1, 0, 6'h03, 32'hFFFF, 0, 1, 0); wait_idle();
    do_req(0, 3, 0, 6'h00, 0, 0, 1, 0); wait_idle();
    mem_check();

    // reset during the WRITE of a byte store
    saved = ref_mem[2];
    do_req(1, 0, 0, 6'h09, 32'h00000077, 0, 0, 0);
    @(posedge clk); #1;
    check("write_state_we", 32'(bus.mem_we), 1);
    rst_n = 0;
    q.delete();
    ref_mem[2] = saved;
    #1;
    check("async_we_drop", 32'(bus.mem_we), 0);
    check("async_resp_drop", 32'(bus.resp_valid), 0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 1);
    check("post_rst_resp", 32'(bus.resp_valid), 0);
    check("mem08_kept", tbmem[2], 32'hDEA5BEEF);

    // back-to-back loads with req_valid held high
    resp_base = n_resp;
    do_req(0, 2, 0, 6'h08, 0, 1, 1, 32'hDEA5BEEF);
    do_req(0, 0, 1, 6'h0A, 0, 1, 1, 32'h000000A5);
    do_req(0, 1, 0, 6'h0E, 0, 1, 1, 32'h00001234);
    do_req(0, 1, 1, 6'h0C, 0, 0, 1, 32'h00008000);
    wait_idle();
    check("b2b_pulses", 32'(n_resp - resp_base), 4);
    mem_check();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
